jtkunio_scr_romrq: RTL and testbench
====================================

JTKUNIO_SCR_ROMRQ -- requirements
Module: jtkunio_scr_romrq

Interface
REQ-001 SHALL have parameter OFFSET, default 22'h0, meaning SDRAM word base address of the scroll ROM region.
REQ-002 SHALL have parameter name-free port list as follows; clk  input  1  system clock, single clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rom_cs  input  1  tile fetcher requests data.
REQ-005 rom_addr  input  17  16-bit-word address from tile fetcher; bit 0 ignored, one 32-bit pair per address.
REQ-006 rom_data  output  32  requested pair, {word at addr|1, word at addr&~1}.
REQ-007 rom_ok  output  1  rom_data valid for the current rom_addr.
REQ-008 sdram_addr  output  22  SDRAM word address = OFFSET + {rom_addr[16:1],1'b0}, latched at request.
REQ-009 sdram_req  output  1  SDRAM request, held until acknowledged.
REQ-010 sdram_ack  input  1  one-cycle acknowledge of sdram_req.
REQ-011 sdram_dst  input  1  data on sdram_din belongs to this slot.
REQ-012 sdram_rdy  input  1  sdram_din valid this cycle.
REQ-013 sdram_din  input  16  SDRAM read data.

Function
REQ-014 SHALL hold a 2-entry cache; each entry: valid bit, 16-bit tag (rom_addr[16:1]), 32-bit data.
REQ-015 Hit = rom_cs and any valid entry tag equals rom_addr[16:1]; evaluated combinationally.
REQ-016 rom_ok SHALL equal hit in the same cycle; rom_data SHALL be the hit entry's data, else last driven value held.
REQ-017 rom_ok SHALL drop in the same cycle rom_addr changes to a non-cached address or rom_cs falls.
REQ-018 FSM states: IDLE, REQ, WAIT_LO, WAIT_HI.
REQ-019 IDLE: on rom_cs and miss, latch sdram_addr and tag, go REQ; sdram_req high from next cycle.
REQ-020 REQ: sdram_req high; on sdram_ack, sdram_req low next cycle, go WAIT_LO.
REQ-021 WAIT_LO: on sdram_rdy & sdram_dst, store sdram_din as low half, go WAIT_HI.
REQ-022 WAIT_HI: on sdram_rdy & sdram_dst, write {sdram_din, low} with latched tag into victim entry, set valid, go IDLE.
REQ-023 Victim SHALL be the entry not most recently hit or filled (1-bit LRU); invalid entry chosen first, entry 0 if both invalid.
REQ-024 Minimum miss latency: miss at cycle 0, ack at cycle 1, rdy at cycles 3 and 4 -> rom_ok high cycle 5 if rom_addr unchanged.
REQ-025 rom_addr change during REQ/WAIT: fetch in flight SHALL complete and fill the cache with the latched tag; new miss serviced from IDLE afterwards.
REQ-026 rom_cs low during fetch: fetch completes; no new request issued from IDLE.
REQ-027 sdram_rdy without sdram_dst SHALL be ignored in all states; sdram_rdy in IDLE/REQ ignored.
REQ-028 sdram_ack arriving in the same cycle sdram_req first rises SHALL be accepted.
REQ-029 A hit SHALL never issue an SDRAM request.
REQ-030 sdram_addr arithmetic modulo 2^22; OFFSET wrap-around not checked.

Reset
REQ-031 On rst: both valid bits 0, LRU 0, state IDLE, sdram_req 0, sdram_addr 0, rom_data 0, rom_ok 0.
REQ-032 rst asserted mid-fetch SHALL abort immediately; no cache write; outstanding SDRAM data after release ignored until a new request.

Verification
REQ-033 Cold miss: rst release, rom_cs=1, rom_addr=17'h00A4, OFFSET=22'h10000 -> sdram_req 1 cycle later, sdram_addr=22'h100A4; din 16'h1234 then 16'h5678 -> rom_data=32'h5678_1234, rom_ok=1.
REQ-034 Hit: repeat rom_addr=17'h00A5 after REQ-033 -> rom_ok=1 same cycle, sdram_req stays 0.
REQ-035 Replacement: fill 17'h0010, 17'h0020, hit 17'h0010, fill 17'h0030 -> 17'h0020 evicted, 17'h0010 still hits.
REQ-036 Address change mid-fetch: switch rom_addr 17'h0100 -> 17'h0200 in WAIT_LO -> rom_ok 0 for 0x0200 until second fetch completes; later 0x0100 hits without SDRAM request.
REQ-037 Foreign data: sdram_rdy=1, sdram_dst=0 in WAIT_LO -> state unchanged, no cache write.
REQ-038 Reset mid-fetch: rst in WAIT_HI -> sdram_req 0, rom_ok 0, same address misses again after release.

Source files
------------

// File: rtl/jtkunio_scr_romrq.sv
// jtkunio_scr_romrq: two-entry cache in front of SDRAM for scroll tile ROM reads
module jtkunio_scr_romrq #(
    parameter logic [21:0] OFFSET = 22'h0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_cs,
    input  logic [16:0] rom_addr,
    output logic [31:0] rom_data,
    output logic        rom_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_dst,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_din
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_LO, WAIT_HI} state_t;
    state_t      state, state_nx;
    logic [1:0]  valid;
    logic [15:0] tag [2];
    logic [31:0] data [2];
    logic        lru, hit0, hit1, hit, got, start, fill, victim, addr_unused;
    logic [15:0] req_tag, lo;
    logic [31:0] data_hold;

    assign addr_unused = rom_addr[0];
    assign hit0      = rom_cs & valid[0] & (tag[0] == rom_addr[16:1]);
    assign hit1      = rom_cs & valid[1] & (tag[1] == rom_addr[16:1]);
    assign hit       = hit0 | hit1;
    assign rom_ok    = hit;
    assign rom_data  = hit0 ? data[0] : hit1 ? data[1] : data_hold;
    assign got       = sdram_rdy & sdram_dst;
    assign victim    = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : lru;
    assign sdram_req = state == REQ;

    // fetch sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state plus one-cycle start/fill strobes
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        fill     = 1'b0;
        case (state)
            IDLE:    if (rom_cs && !hit) begin state_nx = REQ; start = 1'b1; end
            REQ:     if (sdram_ack) state_nx = WAIT_LO;
            WAIT_LO: if (got) state_nx = WAIT_HI;
            WAIT_HI: if (got) begin state_nx = IDLE; fill = 1'b1; end
            default: state_nx = IDLE;
        endcase
    end

    // request latch, low-half capture, cache fill and LRU tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 2'b00;
            tag[0]     <= 16'h0;
            tag[1]     <= 16'h0;
            data[0]    <= 32'h0;
            data[1]    <= 32'h0;
            lru        <= 1'b0;
            req_tag    <= 16'h0;
            lo         <= 16'h0;
            sdram_addr <= 22'h0;
            data_hold  <= 32'h0;
        end else begin
            data_hold <= rom_data;
            if (start) begin
                sdram_addr <= OFFSET + {5'd0, rom_addr[16:1], 1'b0};
                req_tag    <= rom_addr[16:1];
            end
            if (state == WAIT_LO && got) lo <= sdram_din;
            if (fill) begin
                valid[victim] <= 1'b1;
                tag[victim]   <= req_tag;
                data[victim]  <= {sdram_din, lo};
                lru           <= ~victim;
            end else if (hit) lru <= ~hit1;
        end
    end
endmodule

// File: tb/tb_jtkunio_scr_romrq.sv
// tb_jtkunio_scr_romrq: directed vector table plus reset-mid-fetch sequence
module tb_jtkunio_scr_romrq;
    logic        clk = 0, rst = 1, rom_cs = 0, sdram_ack = 0, sdram_dst = 0, sdram_rdy = 0;
    logic [16:0] rom_addr = 0;
    logic [15:0] sdram_din = 0;
    logic [31:0] rom_data;
    logic        rom_ok, sdram_req;
    logic [21:0] sdram_addr;
    int          n_vec = 0, n_bad = 0;

    typedef struct {
        logic        cs;
        logic [16:0] addr;
        logic        ack, rdy, dst;
        logic [15:0] din;
        logic        ok, req;
        logic [21:0] sa;
        logic [31:0] data;
    } vec_t;
    vec_t v [51];

    jtkunio_scr_romrq #(.OFFSET(22'h10000)) dut (
        .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .sdram_addr(sdram_addr),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{1, 17'h00A4, 0, 0, 0, 16'h0,    0, 0, 22'h0,     32'h0};
        v[1]  = '{1, 17'h00A4, 1, 0, 0, 16'h0,    0, 1, 22'h100A4, 32'h0};
        v[2]  = '{1, 17'h00A4, 0, 0, 0, 16'h0,    0, 0, 22'h100A4, 32'h0};
        v[3]  = '{1, 17'h00A4, 0, 1, 1, 16'h1234, 0, 0, 22'h100A4, 32'h0};
        v[4]  = '{1, 17'h00A4, 0, 1, 1, 16'h5678, 0, 0, 22'h100A4, 32'h0};
        v[5]  = '{1, 17'h00A4, 0, 0, 0, 16'h0,    1, 0, 22'h100A4, 32'h56781234};
        v[6]  = '{1, 17'h00A5, 0, 0, 0, 16'h0,    1, 0, 22'h100A4, 32'h56781234};
        v[7]  = '{0, 17'h00A5, 0, 0, 0, 16'h0,    0, 0, 22'h100A4, 32'h56781234};
        v[8]  = '{1, 17'h0010, 0, 0, 0, 16'h0,    0, 0, 22'h100A4, 32'h56781234};
        v[9]  = '{1, 17'h0010, 1, 0, 0, 16'h0,    0, 1, 22'h10010, 32'h56781234};
        v[10] = '{1, 17'h0010, 0, 1, 0, 16'hFFFF, 0, 0, 22'h10010, 32'h56781234};
        v[11] = '{1, 17'h0010, 0, 1, 1, 16'hAAAA, 0, 0, 22'h10010, 32'h56781234};
        v[12] = '{1, 17'h0010, 0, 1, 1, 16'hBBBB, 0, 0, 22'h10010, 32'h56781234};
        v[13] = '{1, 17'h0010, 0, 0, 0, 16'h0,    1, 0, 22'h10010, 32'hBBBBAAAA};
        v[14] = '{1, 17'h0020, 0, 0, 0, 16'h0,    0, 0, 22'h10010, 32'hBBBBAAAA};
        v[15] = '{1, 17'h0020, 1, 0, 0, 16'h0,    0, 1, 22'h10020, 32'hBBBBAAAA};
        v[16] = '{1, 17'h0020, 0, 1, 1, 16'h1111, 0, 0, 22'h10020, 32'hBBBBAAAA};
        v[17] = '{1, 17'h0020, 0, 1, 1, 16'h2222, 0, 0, 22'h10020, 32'hBBBBAAAA};
        v[18] = '{1, 17'h0020, 0, 0, 0, 16'h0,    1, 0, 22'h10020, 32'h22221111};
        v[19] = '{1, 17'h0010, 0, 0, 0, 16'h0,    1, 0, 22'h10020, 32'hBBBBAAAA};
        v[20] = '{1, 17'h0030, 0, 0, 0, 16'h0,    0, 0, 22'h10020, 32'hBBBBAAAA};
        v[21] = '{1, 17'h0030, 1, 0, 0, 16'h0,    0, 1, 22'h10030, 32'hBBBBAAAA};
        v[22] = '{1, 17'h0030, 0, 1, 1, 16'h3333, 0, 0, 22'h10030, 32'hBBBBAAAA};
        v[23] = '{1, 17'h0030, 0, 1, 1, 16'h4444, 0, 0, 22'h10030, 32'hBBBBAAAA};
        v[24] = '{1, 17'h0030, 0, 0, 0, 16'h0,    1, 0, 22'h10030, 32'h44443333};
        v[25] = '{1, 17'h0010, 0, 0, 0, 16'h0,    1, 0, 22'h10030, 32'hBBBBAAAA};
        v[26] = '{1, 17'h0020, 0, 0, 0, 16'h0,    0, 0, 22'h10030, 32'hBBBBAAAA};
        v[27] = '{1, 17'h0020, 1, 0, 0, 16'h0,    0, 1, 22'h10020, 32'hBBBBAAAA};
        v[28] = '{1, 17'h0020, 0, 1, 1, 16'h5555, 0, 0, 22'h10020, 32'hBBBBAAAA};
        v[29] = '{1, 17'h0020, 0, 1, 1, 16'h6666, 0, 0, 22'h10020, 32'hBBBBAAAA};
        v[30] = '{1, 17'h0020, 0, 0, 0, 16'h0,    1, 0, 22'h10020, 32'h66665555};
        v[31] = '{1, 17'h0010, 0, 0, 0, 16'h0,    1, 0, 22'h10020, 32'hBBBBAAAA};
        v[32] = '{1, 17'h0100, 0, 0, 0, 16'h0,    0, 0, 22'h10020, 32'hBBBBAAAA};
        v[33] = '{1, 17'h0100, 1, 0, 0, 16'h0,    0, 1, 22'h10100, 32'hBBBBAAAA};
        v[34] = '{1, 17'h0200, 0, 0, 0, 16'h0,    0, 0, 22'h10100, 32'hBBBBAAAA};
        v[35] = '{1, 17'h0200, 0, 1, 1, 16'h7777, 0, 0, 22'h10100, 32'hBBBBAAAA};
        v[36] = '{1, 17'h0200, 0, 1, 1, 16'h8888, 0, 0, 22'h10100, 32'hBBBBAAAA};
        v[37] = '{1, 17'h0200, 0, 0, 0, 16'h0,    0, 0, 22'h10100, 32'hBBBBAAAA};
        v[38] = '{1, 17'h0200, 1, 0, 0, 16'h0,    0, 1, 22'h10200, 32'hBBBBAAAA};
        v[39] = '{1, 17'h0200, 0, 1, 1, 16'h9999, 0, 0, 22'h10200, 32'hBBBBAAAA};
        v[40] = '{1, 17'h0200, 0, 1, 1, 16'h0A0A, 0, 0, 22'h10200, 32'hBBBBAAAA};
        v[41] = '{1, 17'h0200, 0, 0, 0, 16'h0,    1, 0, 22'h10200, 32'h0A0A9999};
        v[42] = '{1, 17'h0100, 0, 0, 0, 16'h0,    1, 0, 22'h10200, 32'h88887777};
        v[43] = '{1, 17'h0101, 0, 0, 0, 16'h0,    1, 0, 22'h10200, 32'h88887777};
        v[44] = '{1, 17'h0300, 0, 0, 0, 16'h0,    0, 0, 22'h10200, 32'h88887777};
        v[45] = '{0, 17'h0300, 1, 0, 0, 16'h0,    0, 1, 22'h10300, 32'h88887777};
        v[46] = '{0, 17'h0300, 0, 1, 1, 16'h0001, 0, 0, 22'h10300, 32'h88887777};
        v[47] = '{0, 17'h0300, 0, 1, 1, 16'h0002, 0, 0, 22'h10300, 32'h88887777};
        v[48] = '{0, 17'h0300, 0, 0, 0, 16'h0,    0, 0, 22'h10300, 32'h88887777};
        v[49] = '{0, 17'h0300, 0, 0, 0, 16'h0,    0, 0, 22'h10300, 32'h88887777};
        v[50] = '{1, 17'h0300, 0, 0, 0, 16'h0,    1, 0, 22'h10300, 32'h00020001};

        step();
        chk("rst_ok", {31'd0, rom_ok}, 0);
        chk("rst_req", {31'd0, sdram_req}, 0);
        chk("rst_sa", {10'd0, sdram_addr}, 0);
        chk("rst_data", rom_data, 0);
        step();
        rst = 0;

        for (int i = 0; i < 51; i++) begin
            rom_cs = v[i].cs; rom_addr = v[i].addr; sdram_ack = v[i].ack;
            sdram_rdy = v[i].rdy; sdram_dst = v[i].dst; sdram_din = v[i].din;
            #1;
            chk($sformatf("v%0d_ok", i), {31'd0, rom_ok}, {31'd0, v[i].ok});
            chk($sformatf("v%0d_req", i), {31'd0, sdram_req}, {31'd0, v[i].req});
            chk($sformatf("v%0d_sa", i), {10'd0, sdram_addr}, {10'd0, v[i].sa});
            chk($sformatf("v%0d_data", i), rom_data, v[i].data);
            step();
        end

        rom_cs = 1; rom_addr = 17'h0400; sdram_ack = 0; sdram_rdy = 0; sdram_dst = 0;
        #1 chk("mr_miss", {31'd0, rom_ok}, 0);
        step();
        sdram_ack = 1;
        chk("mr_req", {31'd0, sdram_req}, 1);
        step();
        sdram_ack = 0; sdram_rdy = 1; sdram_dst = 1; sdram_din = 16'hCAFE;
        step();
        sdram_rdy = 0; rst = 1;
        #1;
        chk("mr_rst_req", {31'd0, sdram_req}, 0);
        chk("mr_rst_ok", {31'd0, rom_ok}, 0);
        chk("mr_rst_sa", {10'd0, sdram_addr}, 0);
        chk("mr_rst_data", rom_data, 0);
        step();
        rst = 0; rom_cs = 0; sdram_rdy = 1; sdram_dst = 1; sdram_din = 16'hBEEF;
        step();
        chk("mr_stale_req", {31'd0, sdram_req}, 0);
        step();
        sdram_rdy = 0; rom_cs = 1; rom_addr = 17'h0400;
        #1 chk("mr_remiss", {31'd0, rom_ok}, 0);
        step();
        chk("mr_rereq", {31'd0, sdram_req}, 1);
        chk("mr_resa", {10'd0, sdram_addr}, {10'd0, 22'h10400});
        rom_addr = 17'h0300;
        #1 chk("mr_old_gone", {31'd0, rom_ok}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
